// File: rtl/spike_window_counter.sv
// spike_window_counter
//   Counts spikes from a neuron's 1-bit spike output over fixed-length windows.
//   Each completed window's count goes into a small FIFO. That FIFO is a
//   first-word-fall-through queue drained by a valid/ready stream, so the
//   neuron side never stalls.
//
// Ports
//   clk           clock, all logic on rising edge
//   reset         synchronous active-high reset
//   enable        1 = run windows, 0 = abort current window and idle
//   spike_in      spike pulse, sampled every cycle while counting
//   window_len    window length in cycles, latched at window start (0 -> 1)
//   clr_overflow  clears the sticky overflow flag
//   out_valid     FIFO non-empty
//   out_ready     consumer accepts head entry
//   out_count     head entry spike count (saturating)
//   out_sat       head entry count saturated
//   out_seq       head entry window sequence number
//   overflow      sticky: a completed window was dropped because FIFO was full
module spike_window_counter #(
  parameter int CNT_W      = 8,
  parameter int WIN_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             spike_in,
  input  logic [WIN_W-1:0] window_len,
  input  logic             clr_overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count,
  output logic             out_sat,
  output logic [7:0]       out_seq,
  output logic             overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [WIN_W-1:0] ONE_W = 1;

  typedef enum logic [0:0] {IDLE, COUNT} state_t;

  state_t           state, state_nx;
  logic [WIN_W-1:0] remaining, remaining_nx;
  logic [WIN_W-1:0] start_rem;
  logic [CNT_W-1:0] count, count_nx, count_inc;
  logic             sat, sat_nx, sat_inc;
  logic [7:0]       seq, seq_nx;
  logic             push;

  // Remaining-cycles counter starts at L-1 so that remaining==0 marks the
  // L-th sampled cycle; a programmed length of 0 behaves as 1.
  assign start_rem = (window_len == '0) ? '0 : window_len - ONE_W;

  // Count including this cycle's spike; sticks at all-ones once an
  // increment past the maximum is attempted.
  always_comb begin
    count_inc = count;
    sat_inc   = sat;
    if (spike_in) begin
      if (count == '1) begin
        sat_inc = 1'b1;
      end else begin
        count_inc = count + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      remaining <= '0;
      count     <= '0;
      sat       <= 1'b0;
      seq       <= '0;
    end else begin
      state     <= state_nx;
      remaining <= remaining_nx;
      count     <= count_nx;
      sat       <= sat_nx;
      seq       <= seq_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    remaining_nx = remaining;
    count_nx     = count;
    sat_nx       = sat;
    seq_nx       = seq;
    push         = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable) begin
          state_nx     = COUNT;
          remaining_nx = start_rem;
          count_nx     = '0;
          sat_nx       = 1'b0;
        end
      end
      COUNT: begin
        if (!enable) begin
          state_nx = IDLE;
        end else if (remaining == '0) begin
          // Last sampled cycle: emit and immediately start the next window.
          push         = 1'b1;
          seq_nx       = seq + 8'd1;
          remaining_nx = start_rem;
          count_nx     = '0;
          sat_nx       = 1'b0;
        end else begin
          remaining_nx = remaining - ONE_W;
          count_nx     = count_inc;
          sat_nx       = sat_inc;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Result FIFO: pointers carry one extra wrap bit to tell full from empty.
  logic [CNT_W-1:0] mem_count [FIFO_DEPTH];
  logic             mem_sat   [FIFO_DEPTH];
  logic [7:0]       mem_seq   [FIFO_DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             empty, full, pop, wr_en, drop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = !empty && out_ready;
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  assign out_valid = !empty;
  assign out_count = mem_count[rd_ptr[AW-1:0]];
  assign out_sat   = mem_sat[rd_ptr[AW-1:0]];
  assign out_seq   = mem_seq[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_count[i] <= '0;
        mem_sat[i]   <= 1'b0;
        mem_seq[i]   <= '0;
      end
    end else begin
      if (wr_en) begin
        mem_count[wr_ptr[AW-1:0]] <= count_inc;
        mem_sat[wr_ptr[AW-1:0]]   <= sat_inc;
        mem_seq[wr_ptr[AW-1:0]]   <= seq;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // A drop in the same cycle as a clear leaves the flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_overflow) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spike_window_counter.sv
// Directed testbench for spike_window_counter (CNT_W=8, WIN_W=9, FIFO_DEPTH=4).
// Inputs change 1 time unit after each rising edge; outputs are sampled at
// that same point, so they reflect the state after the edge just passed.
module tb_spike_window_counter;

  logic       clk = 1'b0;
  logic       reset, enable, spike_in, clr_overflow, out_ready;
  logic [8:0] window_len;
  logic       out_valid, out_sat, overflow;
  logic [7:0] out_count, out_seq;

  int errors = 0;
  int checks = 0;

  spike_window_counter #(.CNT_W(8), .WIN_W(9), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .spike_in(spike_in),
    .window_len(window_len), .clr_overflow(clr_overflow),
    .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count),
    .out_sat(out_sat), .out_seq(out_seq), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; spike_in = 1'b0; out_ready = 1'b0;
    clr_overflow = 1'b0; window_len = 9'd0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %0b want 0", overflow); end
    checks++; if (out_count !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", out_count); end
    checks++; if (out_sat !== 1'b0) begin errors++; $display("FAIL reset_sat: got %0b want 0", out_sat); end
    checks++; if (out_seq !== 8'd0) begin errors++; $display("FAIL reset_seq: got %0d want 0", out_seq); end
  endtask

  task automatic test_basic();
    do_reset();
    out_ready = 1'b1; window_len = 9'd10; enable = 1'b1;
    tick();
    for (int i = 1; i <= 10; i++) begin
      spike_in = (i == 2 || i == 5 || i == 9);
      if (i == 4) window_len = 9'd3;  // must not shorten the running window
      tick();
      if (i == 9) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %0b want 0", out_valid); end
      end
    end
    spike_in = 1'b0; enable = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %0b want 1", out_valid); end
    checks++; if (out_count !== 8'd3) begin errors++; $display("FAIL basic_count: got %0d want 3", out_count); end
    checks++; if (out_sat !== 1'b0) begin errors++; $display("FAIL basic_sat: got %0b want 0", out_sat); end
    checks++; if (out_seq !== 8'd0) begin errors++; $display("FAIL basic_seq: got %0d want 0", out_seq); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_popped: got %0b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    window_len = 9'd4; enable = 1'b1;
    tick();
    for (int i = 1; i <= 8; i++) begin
      spike_in = (i == 4 || i == 5);
      tick();
      if (i == 4) begin
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid0: got %0b want 1", out_valid); end
        checks++; if (out_count !== 8'd1) begin errors++; $display("FAIL b2b_count0: got %0d want 1", out_count); end
        checks++; if (out_seq !== 8'd0) begin errors++; $display("FAIL b2b_seq0: got %0d want 0", out_seq); end
      end
    end
    spike_in = 1'b0; enable = 1'b0; out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid1: got %0b want 1", out_valid); end
    checks++; if (out_count !== 8'd1) begin errors++; $display("FAIL b2b_count1: got %0d want 1", out_count); end
    checks++; if (out_seq !== 8'd1) begin errors++; $display("FAIL b2b_seq1: got %0d want 1", out_seq); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained: got %0b want 0", out_valid); end
  endtask

  task automatic test_saturation();
    do_reset();
    window_len = 9'd300; enable = 1'b1; spike_in = 1'b1;
    tick();
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (i == 299) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sat_early_valid: got %0b want 0", out_valid); end
      end
    end
    enable = 1'b0; spike_in = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sat_valid: got %0b want 1", out_valid); end
    checks++; if (out_count !== 8'd255) begin errors++; $display("FAIL sat_count: got %0d want 255", out_count); end
    checks++; if (out_sat !== 1'b1) begin errors++; $display("FAIL sat_flag: got %0b want 1", out_sat); end
    tick();
  endtask

  task automatic test_overflow();
    logic [7:0] exp_seq [4];
    exp_seq = '{8'd1, 8'd2, 8'd3, 8'd6};
    do_reset();
    window_len = 9'd2; enable = 1'b1; spike_in = 1'b1;
    tick();
    for (int i = 1; i <= 12; i++) begin
      clr_overflow = (i >= 11);
      tick();
      if (i == 8) begin
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_full_no_ovf: got %0b want 0", overflow); end
      end
      if (i == 10) begin
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %0b want 1", overflow); end
      end
      if (i == 11) begin
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr: got %0b want 0", overflow); end
      end
      if (i == 12) begin
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_beats_clr: got %0b want 1", overflow); end
      end
    end
    clr_overflow = 1'b0; enable = 1'b0;
    tick();
    checks++; if (out_seq !== 8'd0) begin errors++; $display("FAIL ovf_head_seq: got %0d want 0", out_seq); end
    checks++; if (out_count !== 8'd2) begin errors++; $display("FAIL ovf_head_count: got %0d want 2", out_count); end
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr_idle: got %0b want 0", overflow); end
    // push (seq 6) and pop (seq 0) on the same edge while full
    enable = 1'b1;
    tick(); tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0; enable = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_push_pop_full: got %0b want 0", overflow); end
    tick();
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL drain_valid[%0d]: got %0b want 1", k, out_valid); end
      checks++; if (out_seq !== exp_seq[k]) begin errors++; $display("FAIL drain_seq[%0d]: got %0d want %0d", k, out_seq, exp_seq[k]); end
      checks++; if (out_count !== 8'd2) begin errors++; $display("FAIL drain_count[%0d]: got %0d want 2", k, out_count); end
      tick();
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: got %0b want 0", out_valid); end
  endtask

  task automatic test_abort();
    do_reset();
    window_len = 9'd8; enable = 1'b1; spike_in = 1'b1;
    tick();
    for (int i = 1; i <= 4; i++) tick();
    enable = 1'b0;
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_no_entry: got %0b want 0", out_valid); end
    window_len = 9'd3; enable = 1'b1;
    tick();
    for (int i = 1; i <= 3; i++) tick();
    enable = 1'b0; spike_in = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL abort_new_valid: got %0b want 1", out_valid); end
    checks++; if (out_count !== 8'd3) begin errors++; $display("FAIL abort_new_count: got %0d want 3", out_count); end
    checks++; if (out_seq !== 8'd0) begin errors++; $display("FAIL abort_seq: got %0d want 0", out_seq); end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    window_len = 9'd2; enable = 1'b1;
    tick();
    for (int i = 1; i <= 11; i++) tick();
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL rmid_pre_ovf: got %0b want 1", overflow); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rmid_pre_valid: got %0b want 1", out_valid); end
    reset = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %0b want 0", out_valid); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rmid_ovf: got %0b want 0", overflow); end
    reset = 1'b0; window_len = 9'd0; spike_in = 1'b1;
    tick(); tick();
    enable = 1'b0; spike_in = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rmid_new_valid: got %0b want 1", out_valid); end
    checks++; if (out_seq !== 8'd0) begin errors++; $display("FAIL rmid_seq: got %0d want 0", out_seq); end
    checks++; if (out_count !== 8'd1) begin errors++; $display("FAIL rmid_len0_count: got %0d want 1", out_count); end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_saturation();
    test_overflow();
    test_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
